// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and default addresses.
// Used by fetch_ctrl, fetch_buf and fetch_ctrl_if.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Instruction addresses are word aligned; low bits of any target are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction-memory request channel plus the F/D boundary and redirect inputs.
// master = fetch_ctrl side, slave = memory / decode side.
interface fetch_ctrl_if;
    import cpu_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_stall;

    logic        br_req;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_ack, imem_rdata, id_stall, br_req, br_target,
        input  exc_req, eret_req, epc
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_ack, imem_rdata, id_stall, br_req, br_target,
        output exc_req, eret_req, epc
    );

endinterface

// File: rtl/fetch_buf.sv
// Single-entry F/D output buffer: flush beats fill, fill beats consume,
// so a consume in the same cycle as a fill keeps one instruction per cycle flowing.
module fetch_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fill,
    input  logic [31:0] fill_pc,
    input  logic [31:0] fill_instr,
    input  logic        consume,
    input  logic        flush,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        valid_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= 1'b0;
            pc_reg    <= '0;
            instr_reg <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (fill) begin
            valid_reg <= 1'b1;
            pc_reg    <= fill_pc;
            instr_reg <= fill_instr;
        end else if (consume) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign pc    = pc_reg;
    assign instr = instr_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues imem requests, applies delayed (MIPS delay-slot) redirects.
// Exception/eret entry with DRAIN of an outstanding request is built only with FETCH_CTRL_EXC_EN.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
)
(
    input  logic         clk,
    input  logic         reset_n,
    fetch_ctrl_if.master bus
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic         lock_reg;
    logic         redir_vld_reg;
    logic [31:0]  redir_pc_reg;
    logic [31:0]  pend_pc_reg;

    logic         req;
    logic         fire;
    logic         consume;
    logic         fill;
    logic         br_accept;
    logic [31:0]  br_pc;
    logic         exc_hit;
    logic [31:0]  exc_pc;
    logic         drain_needed;

    logic         buf_valid;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_instr;

`ifdef FETCH_CTRL_EXC_EN
    assign exc_hit = bus.exc_req | bus.eret_req;
    assign exc_pc  = bus.exc_req ? EXC_VECTOR : word_align(bus.epc);
`else
    logic unused_exc;
    assign unused_exc = ^{bus.exc_req, bus.eret_req, bus.epc, EXC_VECTOR};
    assign exc_hit    = 1'b0;
    assign exc_pc     = '0;
`endif

    // A locked request keeps going regardless of stall so the address never moves under it.
    assign req          = lock_reg | ((state_reg == RUN) & (!buf_valid | !bus.id_stall));
    assign fire         = req & bus.imem_ack;
    assign consume      = buf_valid & !bus.id_stall;
    assign fill         = fire & (state_reg == RUN) & !exc_hit;
    assign br_pc        = word_align(bus.br_target);
    assign br_accept    = bus.br_req & !bus.id_stall & (state_reg == RUN) & !exc_hit;
    assign drain_needed = req & !bus.imem_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            lock_reg      <= 1'b0;
            redir_vld_reg <= 1'b0;
            redir_pc_reg  <= '0;
            pend_pc_reg   <= '0;
        end else begin
            if (fire) begin
                lock_reg <= 1'b0;
            end else if (req) begin
                lock_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    state_reg <= RUN;
                    if (exc_hit) begin
                        pc_reg <= exc_pc;
                    end
                end

                RUN: begin
                    if (exc_hit) begin
                        redir_vld_reg <= 1'b0;
                        // An unacked request must finish at its current address before the PC moves.
                        if (drain_needed) begin
                            state_reg   <= DRAIN;
                            pend_pc_reg <= exc_pc;
                        end else begin
                            pc_reg <= exc_pc;
                        end
                    end else if (fire) begin
                        // The acked fetch is the delay slot of any redirect seen so far.
                        if (br_accept) begin
                            pc_reg <= br_pc;
                        end else if (redir_vld_reg) begin
                            pc_reg <= redir_pc_reg;
                        end else begin
                            pc_reg <= pc_reg + 32'd4;
                        end
                        redir_vld_reg <= 1'b0;
                    end else if (br_accept) begin
                        redir_vld_reg <= 1'b1;
                        redir_pc_reg  <= br_pc;
                    end
                end

                DRAIN: begin
                    if (fire) begin
                        state_reg <= RUN;
                        pc_reg    <= exc_hit ? exc_pc : pend_pc_reg;
                    end else if (exc_hit) begin
                        pend_pc_reg <= exc_pc;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .fill       (fill),
        .fill_pc    (pc_reg),
        .fill_instr (bus.imem_rdata),
        .consume    (consume),
        .flush      (exc_hit),
        .valid      (buf_valid),
        .pc         (buf_pc),
        .instr      (buf_instr)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_reg;
    assign bus.if_valid  = buf_valid;
    assign bus.if_pc     = buf_pc;
    assign bus.if_instr  = buf_instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scenarios followed by randomized ack/stall/redirect traffic, all checked against
// a transaction-level model of the fetch stream (next fetch address, pending redirect, output buffer).
module tb_fetch_ctrl;
    import cpu_pkg::*;

`ifdef FETCH_CTRL_EXC_EN
    localparam bit EXC_BUILD = 1'b1;
`else
    localparam bit EXC_BUILD = 1'b0;
`endif

    logic clk;
    logic reset_n;
    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_started, m_drain, m_out, m_pend, m_bv;
    logic [31:0] m_next, m_pend_tgt, m_drain_pc, m_bpc, m_binstr;

    // per-cycle exception knobs and last observed request
    bit          exc_k, eret_k;
    logic [31:0] epc_k;
    bit          last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]} + 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_drain = 0; m_out = 0; m_pend = 0; m_bv = 0;
        m_next = RESET_PC_DEF; m_pend_tgt = '0; m_drain_pc = '0;
        m_bpc = '0; m_binstr = '0;
    endtask

    // Entered and left at a falling clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        bus.imem_ack = 0; bus.imem_rdata = '0; bus.id_stall = 0;
        bus.br_req = 0; bus.br_target = '0; bus.exc_req = 0; bus.eret_req = 0; bus.epc = '0;
        #1;
        chk("rst_req",      {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid",    {31'd0, bus.if_valid}, 32'd0);
        chk("rst_pc",       bus.if_pc,             32'd0);
        chk("rst_instr",    bus.if_instr,          32'd0);
        chk("rst_addr",     bus.imem_addr,         RESET_PC_DEF);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic cycle(input bit stall, input bit br, input logic [31:0] tgt, input bit ack_en);
        bit          req, fire, cons, bracc, ehit;
        logic [31:0] a, newpc;
        bus.id_stall  = stall;
        bus.br_req    = br;
        bus.br_target = tgt;
        bus.exc_req   = exc_k;
        bus.eret_req  = eret_k;
        bus.epc       = epc_k;
        #1;
        req = bus.imem_req;
        a   = bus.imem_addr;
        last_req  = req;
        last_addr = a;
        bus.imem_ack   = ack_en;
        bus.imem_rdata = mem_word(a);
        #1;
        chk("req", {31'd0, req}, {31'd0, m_drain | m_out | (m_started & (!m_bv | !stall))});
        if (req) chk("addr", a, m_next);
        chk("if_valid", {31'd0, bus.if_valid}, {31'd0, m_bv});
        if (m_bv) begin
            chk("if_pc", bus.if_pc, m_bpc);
            chk("if_instr", bus.if_instr, m_binstr);
        end

        fire  = req & ack_en;
        cons  = m_bv & !stall;
        ehit  = EXC_BUILD & (exc_k | eret_k);
        newpc = exc_k ? EXC_VECTOR_DEF : {epc_k[31:2], 2'b00};
        bracc = br & !stall & m_started & !m_drain & !ehit;
        if (ehit) begin
            m_bv = 0;
            m_pend = 0;
            if (m_drain) begin
                if (fire) begin m_next = newpc; m_drain = 0; end
                else m_drain_pc = newpc;
            end else if (fire || !req) begin
                m_next = newpc;
            end else begin
                m_drain = 1;
                m_drain_pc = newpc;
            end
        end else if (m_drain) begin
            if (fire) begin m_drain = 0; m_next = m_drain_pc; end
        end else if (fire) begin
            m_bv = 1; m_bpc = a; m_binstr = mem_word(a);
            m_next = bracc ? {tgt[31:2], 2'b00} : (m_pend ? m_pend_tgt : a + 32'd4);
            m_pend = 0;
        end else begin
            if (cons) m_bv = 0;
            if (bracc) begin m_pend = 1; m_pend_tgt = {tgt[31:2], 2'b00}; end
        end
        m_out = req & !ack_en;
        m_started = 1;

        @(posedge clk);
        @(negedge clk);
        bus.imem_ack = 0;
        exc_k = 0; eret_k = 0; epc_k = '0;
    endtask

    initial begin
        reset_n = 1'b1;
        exc_k = 0; eret_k = 0; epc_k = '0;
        bus.imem_ack = 0; bus.imem_rdata = '0; bus.id_stall = 0;
        bus.br_req = 0; bus.br_target = '0; bus.exc_req = 0; bus.eret_req = 0; bus.epc = '0;
        model_reset();
        #2;

        // zero-wait stream
        do_reset();
        cycle(0, 0, 0, 1);
        chk("idle_req", {31'd0, last_req}, 32'd0);
        cycle(0, 0, 0, 1); chk("zw_a0", last_addr, 32'h3000);
        cycle(0, 0, 0, 1); chk("zw_a1", last_addr, 32'h3004);
        cycle(0, 0, 0, 1); chk("zw_a2", last_addr, 32'h3008);
        chk("zw_ifpc", bus.if_pc, 32'h3008);

        // ack held off three cycles
        do_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            chk("wait_addr", last_addr, 32'h3004);
            chk("wait_valid", {31'd0, bus.if_valid}, 32'd0);
        end
        cycle(0, 0, 0, 1); chk("wait_ack_addr", last_addr, 32'h3004);
        chk("wait_ifpc", bus.if_pc, 32'h3004);

        // decode stall with 0x3008 buffered
        do_reset();
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 1);
            chk("stall_req", {31'd0, last_req}, 32'd0);
            chk("stall_ifpc", bus.if_pc, 32'h3008);
        end
        cycle(0, 0, 0, 1); chk("stall_rel_addr", last_addr, 32'h300C);

        // redirect with delay slot, then same-cycle redirect with unaligned target
        do_reset();
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h3100, 0); chk("ds_addr", last_addr, 32'h3010);
        cycle(0, 0, 0, 1);        chk("ds_ack", last_addr, 32'h3010);
        chk("ds_ifpc", bus.if_pc, 32'h3010);
        cycle(0, 0, 0, 1);        chk("br_addr", last_addr, 32'h3100);
        cycle(0, 1, 32'h3102, 1); chk("br2_ds", last_addr, 32'h3104);
        cycle(0, 0, 0, 1);        chk("br2_addr", last_addr, 32'h3100);

        // two redirects before the delay slot completes: latest wins
        cycle(0, 1, 32'h3200, 0);
        cycle(0, 1, 32'h3300, 0);
        cycle(0, 0, 0, 1);        chk("latest_ds", last_addr, 32'h3104);
        cycle(0, 0, 0, 1);        chk("latest_addr", last_addr, 32'h3300);

`ifdef FETCH_CTRL_EXC_EN
        // exception during a locked fetch, then eret
        do_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        exc_k = 1;
        cycle(0, 0, 0, 0);
        chk("exc_valid", {31'd0, bus.if_valid}, 32'd0);
        cycle(0, 0, 0, 0); chk("drain_addr", last_addr, 32'h3004);
        cycle(0, 0, 0, 1); chk("drain_ack", last_addr, 32'h3004);
        chk("drain_discard", {31'd0, bus.if_valid}, 32'd0);
        cycle(0, 0, 0, 1); chk("exc_vec", last_addr, 32'h4180);
        eret_k = 1; epc_k = 32'h3040;
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1); chk("eret_addr", last_addr, 32'h3040);
`endif

        // randomized traffic with a reset dropped mid-transfer
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            if (EXC_BUILD && ($urandom_range(0, 40) == 0)) begin
                exc_k  = $urandom_range(0, 1) == 1;
                eret_k = !exc_k || ($urandom_range(0, 3) == 0);
                epc_k  = 32'h3000 + $urandom_range(0, 255);
            end
            cycle($urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0,
                  32'h3000 + $urandom_range(0, 1023),
                  $urandom_range(0, 4) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
